// File: rtl/data_mem_resp.sv
// Word-addressed data RAM responder for the MEM stage; request held stable under stall_o.
// Latency: LATENCY+2 stalled cycles per access, load data valid in the DONE cycle.
// Backpressure: stall_o holds EX/MEM from first sight of a request until the access completes.
module data_mem_resp #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2,
  parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] Address_i,
  input  logic [31:0] Write_data_i,
  output logic [31:0] Read_data_o,
  output logic        stall_o,
  output logic        misalign_o,
  output logic        conflict_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [3:0]         cnt;
  logic               req;
  logic               accept;
  logic               access;
  logic               op_wr;
  logic               op_rd;
  logic [ADDR_W-1:0]  idx;
  logic [31:0]        wdat;
  logic [31:0]        mem [DEPTH_WORDS];

  // Upper address bits are don't-care: the array wraps modulo DEPTH_WORDS.
  logic unused_addr;
  assign unused_addr = ^Address_i[31:ADDR_W+2];

  assign req    = MemRead_i | MemWrite_i;
  assign accept = (state == IDLE) & req;
  assign access = (state == BUSY) & (cnt == 4'd0);

  // Gated by rst so the pipeline is released the moment reset is applied.
  assign stall_o = rst & (accept | (state == BUSY));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req) state_nxt = BUSY;
      BUSY:    if (cnt == 4'd0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt   <= 4'd0;
      op_wr <= 1'b0;
      op_rd <= 1'b0;
      idx   <= '0;
      wdat  <= 32'd0;
    end else if (accept) begin
      cnt   <= 4'(LATENCY);
      op_wr <= MemWrite_i;
      // A simultaneous write takes priority; the read half is dropped.
      op_rd <= MemRead_i & ~MemWrite_i;
      idx   <= Address_i[ADDR_W+1:2];
      wdat  <= Write_data_i;
    end else if ((state == BUSY) && (cnt != 4'd0)) begin
      cnt <= cnt - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      misalign_o <= 1'b0;
      conflict_o <= 1'b0;
    end else if (accept) begin
      if (Address_i[1:0] != 2'b00) misalign_o <= 1'b1;
      if (MemRead_i && MemWrite_i) conflict_o <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      Read_data_o <= 32'd0;
    end else if (access && op_rd) begin
      Read_data_o <= mem[idx];
    end
  end

  // Array contents survive reset; an abandoned write never reaches its access edge.
  always_ff @(posedge clk) begin
    if (access && op_wr) begin
      mem[idx] <= wdat;
    end
  end

endmodule
